fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RISC-V pipeline: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes PCWrite/stall from the hazard detection unit, branch flush/target from ID, and the global memory stall from the data cache.
- Feeds ID with {pc, instr, valid}. A one-entry hold buffer absorbs instructions returned while the pipeline is frozen.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding driven on IF_ID_instr_o when the slot is empty (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin fetching; sampled in IDLE only.
- PCWrite_i  in  1  from hazard unit; 0 freezes PC and IF/ID.
- Stall_i  in  1  from hazard unit; 1 freezes PC and IF/ID.
- MemStall_i  in  1  data-cache stall; freezes the whole stage; highest priority.
- Flush_i  in  1  branch taken in ID.
- BranchTarget_i  in  32  redirect PC, valid with Flush_i.
- imem_req_o  out  1  instruction fetch request.
- imem_addr_o  out  32  fetch address.
- imem_ack_i  in  1  data valid; may be asserted in the same cycle as req.
- imem_data_i  in  32  fetched instruction.
- IF_ID_pc_o  out  32  PC of the instruction in IF/ID.
- IF_ID_instr_o  out  32  instruction in IF/ID.
- IF_ID_valid_o  out  1  IF/ID slot holds a real instruction.
- fetch_busy_o  out  1  a request is outstanding (FETCH state with no ack yet).

Behaviour:
- advance = PCWrite_i & ~Stall_i & ~MemStall_i.
- redirect = Flush_i & advance. A flush coincident with any stall is ignored because the branch stays in ID.
- Reset (async): state=IDLE, pc_q=RESET_PC, IF_ID_pc_o=0, IF_ID_instr_o=NOP_INSTR, IF_ID_valid_o=0, imem_req_o=0, imem_addr_o=RESET_PC, drop_q=0, hold buffer empty, fetch_busy_o=0. Assertion mid-transaction drops imem_req_o immediately.
- IDLE: req=0. start_i=1 -> FETCH next cycle.
- FETCH: req=1, imem_addr_o=pc_q. The address must stay stable while req=1 and ack=0.
  - ack & drop_q: discard data; pc_q<=redirect_q; drop_q<=0; stay FETCH.
  - ack & redirect: discard data; IF/ID<=NOP, valid 0; pc_q<=BranchTarget_i.
  - ack & advance & ~Flush_i: IF/ID<={pc_q, imem_data_i, 1}; pc_q<=pc_q+4 (mod 2^32, wraps from 0xFFFF_FFFC to 0).
  - ack & ~advance: capture {pc_q, data} into hold buffer -> HOLD; pc_q unchanged.
  - ~ack & redirect: IF/ID<=NOP, valid 0; drop_q<=1; redirect_q<=BranchTarget_i. A later flush while drop_q=1 overwrites redirect_q.
- HOLD: req=0.
  - redirect: discard hold buffer; IF/ID<=NOP, valid 0; pc_q<=BranchTarget_i -> FETCH.
  - advance: IF/ID<=hold buffer, valid 1; pc_q<=pc_q+4 -> FETCH.
  - otherwise: remain in HOLD.
- Frozen cycles (~advance): IF/ID holds its value exactly; no valid bubble is inserted.
- Throughput: 1 instruction/cycle with same-cycle ack; otherwise 1 per ack.
- IF_ID outputs are registered; imem_req_o/imem_addr_o are decoded from registered state and pc_q.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt_o[31:0] (cycles with valid IF/ID and ~advance) and perf_flush_cnt_o[31:0] (redirect events). Both reset to 0, saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - the state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2);
  - the NOP_INSTR constant;
  - the default RESET_PC.
- One sub-module, if_id_reg: {pc, instr, valid} register with load/flush/hold controls and async reset. Reused by the ID/EX author.

Test Plan:
- Reset then start_i, ack same cycle, no stalls -> IF/ID sees pc 0,4,8 on consecutive cycles with valid=1.
- Stall_i=1 for 3 cycles while ack at pc 8 -> state HOLD, IF/ID holds pc 4 for 3 cycles, then pc 8 loads, next req addr 12.
- Flush_i with target 0x100 while FETCH and ack delayed 2 cycles -> data returned for old addr discarded, next req addr 0x100, IF/ID valid=0 for the gap.
- Flush_i and Stall_i both 1 -> flush ignored, pc_q and IF/ID unchanged.
- MemStall_i=1 with Flush_i=1 and ack -> data captured in HOLD, no redirect; after MemStall_i falls, held instr enters IF/ID.
- rst_i pulsed mid-FETCH -> req falls asynchronously, IF/ID=NOP/valid 0, restart fetches from RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
//   Shared definitions for the front end of the 5-stage RISC-V pipeline.
//   Holds the fetch-stage state encoding, the canonical NOP encoding used to
//   fill empty pipeline slots, the default reset PC and a small PC helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package pipeline_pkg;

    // Fetch-stage controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential PC; wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
//   {pc, instr, valid} pipeline register between two pipeline stages.
//   Priority: flush > load > hold. A flush writes an empty slot
//   (pc 0, NOP encoding, valid 0); with neither control asserted the
//   register keeps its value.
//
//   Ports:
//     clk_i    in   clock, rising edge
//     rst_i    in   asynchronous active-high reset (empty slot)
//     load_i   in   capture pc_i/instr_i/valid_i
//     flush_i  in   replace contents with an empty slot
//     pc_i     in   [31:0] PC to capture
//     instr_i  in   [31:0] instruction to capture
//     valid_i  in   valid flag to capture
//     pc_o     out  [31:0] registered PC
//     instr_o  out  [31:0] registered instruction
//     valid_o  out  registered valid flag
// ----------------------------------------------------------------------------
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = 32'd0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= 32'd0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   IF stage of the 5-stage RISC-V pipeline. Owns the PC, the instruction
//   memory request handshake and the IF/ID register. A one-entry hold buffer
//   keeps an instruction that returns while the pipeline is frozen.
//
//   Optional feature (macro FETCH_PERF_CNT_EN): adds saturating counters
//   perf_stall_cnt_o (cycles with a valid IF/ID slot that cannot advance)
//   and perf_flush_cnt_o (taken redirects).
//
//   Ports:
//     clk_i, rst_i          clock / asynchronous active-high reset
//     start_i               begin fetching (sampled in IDLE only)
//     PCWrite_i, Stall_i    hazard unit: PCWrite_i=0 or Stall_i=1 freezes
//     MemStall_i            data-cache stall, freezes everything
//     Flush_i               branch taken in ID
//     BranchTarget_i[31:0]  redirect target, valid with Flush_i
//     imem_req_o            fetch request (FETCH state)
//     imem_addr_o[31:0]     fetch address (= PC)
//     imem_ack_i            fetch data valid, may come in the request cycle
//     imem_data_i[31:0]     fetched instruction
//     IF_ID_pc_o[31:0]      PC of the instruction in IF/ID
//     IF_ID_instr_o[31:0]   instruction in IF/ID (NOP when empty)
//     IF_ID_valid_o         IF/ID holds a real instruction
//     fetch_busy_o          request outstanding without an ack this cycle
//     perf_stall_cnt_o[31:0], perf_flush_cnt_o[31:0]  (FETCH_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = pipeline_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PCWrite_i,
    input  logic        Stall_i,
    input  logic        MemStall_i,
    input  logic        Flush_i,
    input  logic [31:0] BranchTarget_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] IF_ID_pc_o,
    output logic [31:0] IF_ID_instr_o,
    output logic        IF_ID_valid_o,
    output logic        fetch_busy_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    logic advance;
    logic redirect;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  redirect_q, redirect_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;

    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ifid_pc_in;
    logic [31:0]  ifid_instr_in;

    // A flush that coincides with any stall is ignored: the branch is still
    // sitting in ID and will re-assert Flush_i once the pipeline moves.
    assign advance  = PCWrite_i & ~Stall_i & ~MemStall_i;
    assign redirect = Flush_i & advance;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        redirect_d    = redirect_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_pc_in    = pc_q;
        ifid_instr_in = imem_data_i;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (imem_ack_i && drop_q) begin
                    // Response to a request issued before a redirect: throw it
                    // away and resume at the saved target. A fresh redirect in
                    // this very cycle is newer and wins.
                    drop_d     = 1'b0;
                    pc_d       = redirect ? BranchTarget_i : redirect_q;
                    ifid_flush = advance;
                end else if (imem_ack_i && redirect) begin
                    ifid_flush = 1'b1;
                    pc_d       = BranchTarget_i;
                end else if (imem_ack_i && advance) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4(pc_q);
                end else if (imem_ack_i) begin
                    // Frozen pipeline: park the instruction, PC stays put.
                    hold_pc_d    = pc_q;
                    hold_instr_d = imem_data_i;
                    state_d      = ST_HOLD;
                end else if (redirect) begin
                    // The request in flight cannot be withdrawn (address must
                    // stay stable), so remember to drop its response.
                    ifid_flush = 1'b1;
                    drop_d     = 1'b1;
                    redirect_d = BranchTarget_i;
                end else if (advance) begin
                    // ID consumed its instruction and nothing new arrived.
                    ifid_flush = 1'b1;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    pc_d       = BranchTarget_i;
                    state_d    = ST_FETCH;
                end else if (advance) begin
                    ifid_load     = 1'b1;
                    ifid_pc_in    = hold_pc_q;
                    ifid_instr_in = hold_instr_q;
                    pc_d          = pc_plus4(pc_q);
                    state_d       = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            redirect_q   <= 32'd0;
            hold_pc_q    <= 32'd0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            redirect_q   <= redirect_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Request side is decoded from registered state only, so it drops the
    // instant reset is asserted.
    assign imem_req_o   = (state_q == ST_FETCH);
    assign imem_addr_o  = pc_q;
    assign fetch_busy_o = imem_req_o & ~imem_ack_i;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (ifid_pc_in),
        .instr_i (ifid_instr_in),
        .valid_i (1'b1),
        .pc_o    (IF_ID_pc_o),
        .instr_o (IF_ID_instr_o),
        .valid_o (IF_ID_valid_o)
    );

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (IF_ID_valid_o && !advance) begin
            perf_stall_cnt_d = sat_inc(perf_stall_cnt_q);
        end
        // Only redirects that actually steer the fetch stream are counted.
        if (redirect && (state_q != ST_IDLE)) begin
            perf_flush_cnt_d = sat_inc(perf_flush_cnt_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_cnt_q <= 32'd0;
            perf_flush_cnt_q <= 32'd0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt_o = perf_stall_cnt_q;
    assign perf_flush_cnt_o = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, pcw_i, stall_i, mstall_i, flush_i, ack_i;
    logic [31:0] tgt_i, data_i;
    logic        req_o, valid_o, busy_o;
    logic [31:0] addr_o, ifpc_o, ifinstr_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pstall_o, pflush_o;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start_i),
        .PCWrite_i      (pcw_i),
        .Stall_i        (stall_i),
        .MemStall_i     (mstall_i),
        .Flush_i        (flush_i),
        .BranchTarget_i (tgt_i),
        .imem_req_o     (req_o),
        .imem_addr_o    (addr_o),
        .imem_ack_i     (ack_i),
        .imem_data_i    (data_i),
        .IF_ID_pc_o     (ifpc_o),
        .IF_ID_instr_o  (ifinstr_o),
        .IF_ID_valid_o  (valid_o),
        .fetch_busy_o   (busy_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt_o (pstall_o),
        .perf_flush_cnt_o (pflush_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Instruction word the imaginary memory returns for an address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: what the stage must look like after each edge.
    //   running  : start has been seen
    //   parked   : an instruction is waiting because the pipe was frozen
    //   stale    : queue of redirect targets whose old request is in flight
    // ------------------------------------------------------------------
    bit          m_running;
    bit          m_parked;
    logic [31:0] m_park_pc, m_park_instr;
    logic [31:0] m_stale[$];
    logic [31:0] m_pc;
    logic [31:0] m_if_pc, m_if_instr;
    bit          m_if_valid;
    logic [31:0] m_pstall, m_pflush;

    task automatic model_reset();
        m_running = 0; m_parked = 0; m_stale.delete();
        m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = NOP; m_if_valid = 0;
        m_pstall = 0; m_pflush = 0;
    endtask

    task automatic model_empty_slot();
        m_if_pc = 32'h0; m_if_instr = NOP; m_if_valid = 0;
    endtask

    task automatic model_step();
        bit go, taken;
        go    = pcw_i && !stall_i && !mstall_i;
        taken = flush_i && go;
        if (m_if_valid && !go && m_pstall != 32'hFFFF_FFFF) m_pstall++;
        if (taken && m_running && m_pflush != 32'hFFFF_FFFF) m_pflush++;
        if (!m_running) begin
            if (start_i) m_running = 1;
        end else if (m_parked) begin
            if (taken) begin
                m_parked = 0; model_empty_slot(); m_pc = tgt_i;
            end else if (go) begin
                m_parked = 0;
                m_if_pc = m_park_pc; m_if_instr = m_park_instr; m_if_valid = 1;
                m_pc = m_pc + 4;
            end
        end else if (ack_i && m_stale.size() != 0) begin
            m_pc = taken ? tgt_i : m_stale[0];
            m_stale.delete();
            if (go) model_empty_slot();
        end else if (ack_i && taken) begin
            model_empty_slot(); m_pc = tgt_i;
        end else if (ack_i && go) begin
            m_if_pc = m_pc; m_if_instr = data_i; m_if_valid = 1;
            m_pc = m_pc + 4;
        end else if (ack_i) begin
            m_parked = 1; m_park_pc = m_pc; m_park_instr = data_i;
        end else if (taken) begin
            model_empty_slot();
            m_stale.delete();
            m_stale.push_back(tgt_i);
        end else if (go) begin
            model_empty_slot();
        end
    endtask

    // Compare process: every falling edge, then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            check("req",      {31'd0, req_o},   {31'd0, (m_running && !m_parked)});
            check("addr",     addr_o,           m_pc);
            check("busy",     {31'd0, busy_o},  {31'd0, (m_running && !m_parked && !ack_i)});
            check("if_valid", {31'd0, valid_o}, {31'd0, m_if_valid});
            check("if_instr", ifinstr_o,        m_if_instr);
            check("if_pc",    ifpc_o,           m_if_pc);
`ifdef FETCH_PERF_CNT_EN
            check("perf_stall", pstall_o, m_pstall);
            check("perf_flush", pflush_o, m_pflush);
`endif
            if (!rst) model_step();
        end
    end

    // One clock of stimulus: apply inputs, pass the rising edge, settle.
    task automatic cyc(input bit s, input bit p, input bit st, input bit ms, input bit f,
                       input logic [31:0] t, input bit a, input logic [31:0] d);
        start_i = s; pcw_i = p; stall_i = st; mstall_i = ms; flush_i = f;
        tgt_i = t; ack_i = a; data_i = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        start_i = 0; pcw_i = 0; stall_i = 0; mstall_i = 0; flush_i = 0;
        tgt_i = 0; ack_i = 0; data_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_instr", ifinstr_o, NOP);
        check("rst_pc",    ifpc_o, 32'd0);
        check("rst_req",   {31'd0, req_o}, 32'd0);
        check("rst_addr",  addr_o, 32'd0);

        // Start, then same-cycle acks
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        check("start_req",  {31'd0, req_o}, 32'd1);
        check("start_addr", addr_o, 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 1, mem_word(32'h0));
        check("seq0_pc",    ifpc_o, 32'h0);
        check("seq0_instr", ifinstr_o, 32'hA000_0000);
        check("seq0_valid", {31'd0, valid_o}, 32'd1);
        cyc(0, 1, 0, 0, 0, 0, 1, mem_word(32'h4));
        check("seq1_pc", ifpc_o, 32'h4);

        // Stall for 3 cycles while pc 8 is returned
        cyc(0, 1, 1, 0, 0, 0, 1, mem_word(32'h8));
        check("hold_req", {31'd0, req_o}, 32'd0);
        check("hold_pc1", ifpc_o, 32'h4);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        check("hold_pc2", ifpc_o, 32'h4);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        check("hold_pc3", ifpc_o, 32'h4);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check("unhold_pc",    ifpc_o, 32'h8);
        check("unhold_instr", ifinstr_o, 32'hA000_0008);
        check("unhold_addr",  addr_o, 32'hC);

        // Flush to 0x100 with the ack for 0xC arriving two cycles later
        cyc(0, 1, 0, 0, 1, 32'h100, 0, 0);
        check("fl_valid", {31'd0, valid_o}, 32'd0);
        check("fl_addr_stable", addr_o, 32'hC);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check("fl_gap_valid", {31'd0, valid_o}, 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        check("fl_drop_valid", {31'd0, valid_o}, 32'd0);
        check("fl_new_addr", addr_o, 32'h100);
        cyc(0, 1, 0, 0, 0, 0, 1, mem_word(32'h100));
        check("fl_tgt_pc", ifpc_o, 32'h100);

        // Flush together with Stall_i is ignored
        cyc(0, 1, 1, 0, 1, 32'h200, 0, 0);
        check("flst_pc",    ifpc_o, 32'h100);
        check("flst_valid", {31'd0, valid_o}, 32'd1);
        check("flst_addr",  addr_o, 32'h104);

        // MemStall with flush and ack: data parked, no redirect
        cyc(0, 1, 0, 1, 1, 32'h300, 1, mem_word(32'h104));
        check("ms_req", {31'd0, req_o}, 32'd0);
        check("ms_pc",  ifpc_o, 32'h100);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check("ms_rel_pc",    ifpc_o, 32'h104);
        check("ms_rel_instr", ifinstr_o, 32'hA000_0104);
        check("ms_rel_addr",  addr_o, 32'h108);

        // Redirect out of the hold buffer
        cyc(0, 1, 1, 0, 0, 0, 1, mem_word(32'h108));
        cyc(0, 1, 0, 0, 1, 32'h400, 0, 0);
        check("hr_valid", {31'd0, valid_o}, 32'd0);
        check("hr_addr",  addr_o, 32'h400);

        // PC wrap at the top of the address space
        cyc(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h1234_5678);
        check("wrap_addr0", addr_o, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 0, 0, 0, 1, mem_word(32'hFFFF_FFFC));
        check("wrap_pc",   ifpc_o, 32'hFFFF_FFFC);
        check("wrap_addr", addr_o, 32'h0);

        // Second flush while the first is pending overwrites the target
        cyc(0, 1, 0, 0, 1, 32'h500, 0, 0);
        cyc(0, 1, 0, 0, 1, 32'h600, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
        check("ovr_addr", addr_o, 32'h600);
        cyc(0, 1, 0, 0, 0, 0, 1, mem_word(32'h600));
        check("ovr_pc", ifpc_o, 32'h600);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check("bubble_valid", {31'd0, valid_o}, 32'd0);

        // Reset in the middle of a fetch
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_req",   {31'd0, req_o}, 32'd0);
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_instr", ifinstr_o, NOP);
        check("arst_addr",  addr_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, mem_word(32'h0));
        check("rs_pc",    ifpc_o, 32'h0);
        check("rs_valid", {31'd0, valid_o}, 32'd1);
        check("rs_addr",  addr_o, 32'h4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
